alu_operand_queue: RTL

//  Parametrised successor to the 6502 ALU input mux. Selects two ALU operands
//  (A-side, B-side) from the CPU register set and constants, and captures them
//  as one operand pair into a DEPTH-entry FIFO. The ALU consumes the pairs over
//  a valid/ready handshake, so microcode decode and ALU execution can be decoupled.

---
 rtl/alu_operand_queue_pkg.sv | 25 ++
 rtl/alu_operand_queue_select.sv | 50 +++++
 rtl/alu_operand_queue.sv | 124 ++++++++++++
 3 files changed

// File: rtl/alu_operand_queue_pkg.sv
// Shared ALU input definitions (alu_in_defs): operand-source select codes
// and the constant sources. Imported by the operand queue, the sequencer
// and the bench, so every party decodes the select codes the same way.
package alu_operand_queue_pkg;

  // Width of the architected part of a select code; wider codes are
  // permitted, and any code whose upper bits are non-zero selects ZERO.
  localparam int unsigned ALU_IN_MUX_W = 3;

  typedef enum logic [ALU_IN_MUX_W-1:0] {
    ALU_IN_MUX_ZERO = 3'd0,
    ALU_IN_MUX_A    = 3'd1,
    ALU_IN_MUX_X    = 3'd2,
    ALU_IN_MUX_Y    = 3'd3,
    ALU_IN_MUX_DATA = 3'd4,
    ALU_IN_MUX_SP   = 3'd5,
    ALU_IN_MUX_ONE  = 3'd6,
    ALU_IN_MUX_ONES = 3'd7
  } alu_in_mux_e;

  // Constant sources, held wide and cut down to the datapath width at use.
  localparam logic [63:0] ALU_IN_ONE  = 64'd1;
  localparam logic [63:0] ALU_IN_ONES = '1;

endpackage

// File: rtl/alu_operand_queue_select.sv
// alu_in_select: combinational operand-source decoder. Maps a select code
// and the CPU register set onto one WIDTH-bit operand value. Instantiated
// once for the A side and once for the B side of the operand queue.
module alu_in_select
  import alu_operand_queue_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 3
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [WIDTH-1:0] a_reg,
  input  logic [WIDTH-1:0] x_reg,
  input  logic [WIDTH-1:0] y_reg,
  input  logic [WIDTH-1:0] data_in,
  input  logic [WIDTH-1:0] sp,
  output logic [WIDTH-1:0] value
);

  logic        hi_zero;
  alu_in_mux_e code;

  // Codes beyond the architected range (only possible when SEL_W > 3)
  // must decode to ZERO, so the upper bits gate the whole decode.
  if (SEL_W > ALU_IN_MUX_W) begin : g_wide_sel
    assign hi_zero = (sel[SEL_W-1:ALU_IN_MUX_W] == '0);
  end else begin : g_narrow_sel
    assign hi_zero = 1'b1;
  end

  assign code = alu_in_mux_e'(sel[ALU_IN_MUX_W-1:0]);

  // Source decode; everything not explicitly selected reads as zero.
  always_comb begin
    value = '0;
    if (hi_zero) begin
      case (code)
        ALU_IN_MUX_ZERO: value = '0;
        ALU_IN_MUX_A:    value = a_reg;
        ALU_IN_MUX_X:    value = x_reg;
        ALU_IN_MUX_Y:    value = y_reg;
        ALU_IN_MUX_DATA: value = data_in;
        ALU_IN_MUX_SP:   value = sp;
        ALU_IN_MUX_ONE:  value = ALU_IN_ONE[WIDTH-1:0];
        ALU_IN_MUX_ONES: value = ALU_IN_ONES[WIDTH-1:0];
        default:         value = '0;
      endcase
    end
  end

endmodule

// File: rtl/alu_operand_queue.sv
// alu_operand_queue: selects the A/B ALU operands from the register set and
// constants and queues them as pairs in a DEPTH-entry FIFO drained by the
// ALU over a valid/ready handshake.
// Optional feature macro: ALU_IN_INVERT_EN adds inv_b, which stores the
// B operand ones-complemented (SBC/CMP).
module alu_operand_queue
  import alu_operand_queue_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SEL_W = 3,
  parameter int unsigned DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [SEL_W-1:0]         sel_a,
  input  logic [SEL_W-1:0]         sel_b,
  input  logic [WIDTH-1:0]         a_reg,
  input  logic [WIDTH-1:0]         x_reg,
  input  logic [WIDTH-1:0]         y_reg,
  input  logic [WIDTH-1:0]         data_in,
  input  logic [WIDTH-1:0]         sp,
`ifdef ALU_IN_INVERT_EN
  input  logic                     inv_b,
`endif
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [WIDTH-1:0]         op_a,
  output logic [WIDTH-1:0]         op_b,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_a [DEPTH];
  logic [WIDTH-1:0] mem_b [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;

  logic [WIDTH-1:0] src_a;
  logic [WIDTH-1:0] src_b;
  logic [WIDTH-1:0] store_b;
  logic             push;
  logic             pop;

  alu_in_select #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_sel_a (
    .sel     (sel_a),
    .a_reg   (a_reg),
    .x_reg   (x_reg),
    .y_reg   (y_reg),
    .data_in (data_in),
    .sp      (sp),
    .value   (src_a)
  );

  alu_in_select #(
    .WIDTH (WIDTH),
    .SEL_W (SEL_W)
  ) u_sel_b (
    .sel     (sel_b),
    .a_reg   (a_reg),
    .x_reg   (x_reg),
    .y_reg   (y_reg),
    .data_in (data_in),
    .sp      (sp),
    .value   (src_b)
  );

`ifdef ALU_IN_INVERT_EN
  assign store_b = inv_b ? ~src_b : src_b;
`else
  assign store_b = src_b;
`endif

  // Handshake: readiness and validity come only from registered state, so
  // no combinational path exists from the in_* side to the out_* side.
  assign in_ready  = (count_q != CNT_W'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Head entry is masked to zero while the queue is empty.
  assign op_a = out_valid ? mem_a[rd_ptr] : '0;
  assign op_b = out_valid ? mem_b[rd_ptr] : '0;

  // Operand storage; contents need no reset because count gates visibility.
  // A write during flush is harmless: the pointers are cleared in the same edge.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr] <= src_a;
      mem_b[wr_ptr] <= store_b;
    end
  end

  // Pointers and occupancy; flush overrides any simultaneous push or pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
